filter_bank_arbiter: RTL and testbench

- Collects pair results from NUM_FILTER parallel planar filters, buffers only the passing pairs per lane, and round-robin arbitrates them into one shared force-evaluation pipeline.
- Sits between the filter bank and the force pipeline.
- Drives per-lane almost-full back-pressure to the pair generator.
- Flags lost pairs on overflow.

---
 rtl/filter_bank_arbiter.sv | 153 +++++++++++++++
 tb/tb_filter_bank_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_bank_arbiter.sv
// Per-lane first-word-fall-through FIFOs for passing filter pairs, drained through
// one round-robin-arbitrated output register into the shared force pipeline.
module filter_bank_arbiter #(
  parameter int NUM_FILTER      = 4,
  parameter int LANE_ID_WIDTH   = 2,
  parameter int DATA_WIDTH      = 66,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int ALMOST_FULL_TH  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FILTER-1:0]            in_valid,
  input  logic [NUM_FILTER-1:0]            in_pass,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_data,
  output logic [NUM_FILTER-1:0]            lane_almost_full,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [LANE_ID_WIDTH-1:0]         out_lane,
  output logic                             overflow_err,
  output logic                             all_empty
);

  localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]      mem_q    [NUM_FILTER][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      mem_d    [NUM_FILTER][FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q [NUM_FILTER];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_d [NUM_FILTER];
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q [NUM_FILTER];
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_d [NUM_FILTER];
  logic [CNT_W-1:0]           count_q  [NUM_FILTER];
  logic [CNT_W-1:0]           count_d  [NUM_FILTER];

  logic [LANE_ID_WIDTH-1:0] rr_q, rr_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [LANE_ID_WIDTH-1:0] out_lane_q, out_lane_d;
  logic                     overflow_q, overflow_d;
  logic [NUM_FILTER-1:0]    almost_full_q, almost_full_d;
  logic                     all_empty_q, all_empty_d;

  logic                     load;
  logic                     found;
  logic [LANE_ID_WIDTH-1:0] grant;
  logic [NUM_FILTER-1:0]    rd_en;
  logic [NUM_FILTER-1:0]    wr_en;
  logic                     any_nonempty;
  int                       idx;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rr_d          = rr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_lane_d    = out_lane_q;
    overflow_d    = overflow_q;
    almost_full_d = '0;
    found         = 1'b0;
    grant         = '0;
    rd_en         = '0;
    wr_en         = '0;
    any_nonempty  = 1'b0;
    idx           = 0;
    load          = !out_valid_q || out_ready;

    // Scan lanes starting at the round-robin pointer; first non-empty wins.
    for (int k = 0; k < NUM_FILTER; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_FILTER) idx = idx - NUM_FILTER;
      if (!found && count_q[idx] != '0) begin
        found = 1'b1;
        grant = LANE_ID_WIDTH'(idx);
      end
    end

    if (load) begin
      if (found) begin
        rd_en[grant] = 1'b1;
        out_valid_d  = 1'b1;
        out_data_d   = mem_q[grant][rd_ptr_q[grant]];
        out_lane_d   = grant;
        rr_d         = (grant == LANE_ID_WIDTH'(NUM_FILTER - 1)) ? '0 : grant + LANE_ID_WIDTH'(1);
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    // A full lane still accepts a write when it is popped in the same cycle.
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (in_valid[i] && in_pass[i]) begin
        if (count_q[i] != CNT_W'(FIFO_DEPTH) || rd_en[i]) begin
          wr_en[i]                 = 1'b1;
          mem_d[i][wr_ptr_q[i]]    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
          wr_ptr_d[i]              = wr_ptr_q[i] + FIFO_ADDR_WIDTH'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (rd_en[i]) rd_ptr_d[i] = rd_ptr_q[i] + FIFO_ADDR_WIDTH'(1);
      count_d[i]       = count_q[i] + CNT_W'(wr_en[i]) - CNT_W'(rd_en[i]);
      almost_full_d[i] = (count_d[i] >= CNT_W'(ALMOST_FULL_TH));
      if (count_d[i] != '0) any_nonempty = 1'b1;
    end

    all_empty_d = !any_nonempty && !out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FILTER; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q          <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_lane_q    <= '0;
      overflow_q    <= 1'b0;
      almost_full_q <= '0;
      all_empty_q   <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rr_q          <= rr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_lane_q    <= out_lane_d;
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
      all_empty_q   <= all_empty_d;
    end
  end

  // Storage contents need no reset; counts and pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign lane_almost_full = almost_full_q;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_lane         = out_lane_q;
  assign overflow_err     = overflow_q;
  assign all_empty        = all_empty_q;

endmodule

// File: tb/tb_filter_bank_arbiter.sv
// Bench for filter_bank_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based transaction model of the lane buffers and arbiter.
module tb_filter_bank_arbiter;
  localparam int NF = 4;
  localparam int DW = 66;
  localparam int DEPTH = 8;
  localparam int TH = 6;

  logic               clk;
  logic               rst;
  logic [NF-1:0]      in_valid;
  logic [NF-1:0]      in_pass;
  logic [NF*DW-1:0]   in_data;
  logic [NF-1:0]      lane_almost_full;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [1:0]         out_lane;
  logic               overflow_err;
  logic               all_empty;

  filter_bank_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_pass          (in_pass),
    .in_data          (in_data),
    .lane_almost_full (lane_almost_full),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_lane         (out_lane),
    .overflow_err     (overflow_err),
    .all_empty        (all_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] lane_q [NF][$];
  int            m_rr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_lane;
  bit            m_ovf;
  logic [NF-1:0] m_af;
  bit            m_empty;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int pick;
    int l;
    if (!rst) begin
      for (int i = 0; i < NF; i++) lane_q[i].delete();
      m_rr = 0; m_valid = 0; m_data = '0; m_lane = 0;
      m_ovf = 0; m_af = '0; m_empty = 1;
      return;
    end
    pick = -1;
    if (!m_valid || out_ready) begin
      for (int k = 0; k < NF; k++) begin
        l = (m_rr + k) % NF;
        if (pick < 0 && lane_q[l].size() > 0) pick = l;
      end
      if (pick >= 0) begin
        m_data  = lane_q[pick].pop_front();
        m_lane  = pick;
        m_valid = 1;
        m_rr    = (pick + 1) % NF;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < NF; i++) begin
      if (in_valid[i] && in_pass[i]) begin
        if (lane_q[i].size() < DEPTH) lane_q[i].push_back(in_data[i*DW +: DW]);
        else m_ovf = 1;
      end
    end
    m_empty = !m_valid;
    for (int i = 0; i < NF; i++) begin
      m_af[i] = (lane_q[i].size() >= TH);
      if (lane_q[i].size() != 0) m_empty = 0;
    end
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_lane", out_lane, m_lane[1:0]);
    chk("overflow_err", overflow_err, m_ovf);
    chk("almost_full", lane_almost_full, m_af);
    chk("all_empty", all_empty, m_empty);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    in_pass  = '0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic put(input int lane, input logic [DW-1:0] d);
    in_valid[lane] = 1'b1;
    in_pass[lane]  = 1'b1;
    in_data[lane*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    #2;
    do_reset();
    chk("reset_all_empty", all_empty, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);

    // single pass on lane 2: visible two edges after presentation
    put(2, 66'h15);
    step();
    idle_inputs();
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data", out_data, 66'h15);
    chk("lat_lane", out_lane, 2'd2);
    step();
    chk("lat_empty_after", all_empty, 1'b1);

    // all four lanes at once from rr=0
    do_reset();
    for (int i = 0; i < NF; i++) put(i, rand_data());
    step();
    idle_inputs();
    for (int i = 0; i < NF; i++) begin
      step();
      chk("rr_lane", out_lane, i[1:0]);
    end
    step();
    chk("rr_drained", out_valid, 1'b0);

    // filtered-out results have no effect
    in_valid = '1;
    in_pass  = '0;
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < NF; j++) in_data[j*DW +: DW] = rand_data();
      step();
    end
    idle_inputs();
    chk("nopass_valid", out_valid, 1'b0);
    chk("nopass_ovf", overflow_err, 1'b0);

    // stalled lane 1: one pair parks in the output register, eight fill the FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      put(1, 66'h100 + 66'(i));
      step();
    end
    idle_inputs();
    chk("stall_af", lane_almost_full[1], 1'b1);
    chk("stall_ovf", overflow_err, 1'b1);
    chk("stall_hold", out_data, 66'h100);
    step();
    chk("stall_hold2", out_data, 66'h100);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("drain_order", out_data, 66'h100 + 66'(i));
      step();
    end
    chk("drain_done", out_valid, 1'b0);
    chk("ovf_sticky", overflow_err, 1'b1);

    // full lane 0 written on the same cycle it is popped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put(0, rand_data());
      step();
    end
    out_ready = 1'b1;
    put(0, rand_data());
    step();
    idle_inputs();
    chk("fullpop_ovf", overflow_err, 1'b0);
    chk("fullpop_af", lane_almost_full[0], 1'b1);
    for (int i = 0; i < 12; i++) step();

    // reset with pairs in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(i % NF, rand_data());
      step();
    end
    idle_inputs();
    rst = 1'b0;
    step();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_empty", all_empty, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_stale", out_valid, 1'b0);
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < NF; j++) begin
        in_valid[j] = ($urandom_range(0, 99) < 60);
        in_pass[j]  = ($urandom_range(0, 99) < 70);
        in_data[j*DW +: DW] = rand_data();
      end
      out_ready = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 85 : 30));
      rst = ($urandom_range(0, 999) != 0);
      step();
    end
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("final_empty", all_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
